// File: rtl/data_memory_ctrl_if.sv
// data_memory_ctrl_if: request/response handshake between the MEM-stage load/store unit and the data memory controller.
interface data_memory_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_error;
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-lane data RAM with valid/ready handshake, registered loads and error reporting.
// Define DMEM_ERR_COUNT_EN to build the saturating error counter; otherwise err_count is tied to 0.
module data_memory_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  data_memory_ctrl_if.slave   bus,
  output logic [15:0]         err_count
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int LD    = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
  state_t st, nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word, wdata_sh, shifted, lo_mask, ext;
  logic [LD-1:0]         widx;
  logic [LB-1:0]         lane, lane_q;
  logic [BYTES-1:0]      be;
  logic [3:0]            size_bytes;
  logic [1:0]            sz_q;
  logic                  uns_q, err, accept, wr_en, rd_en;
  assign widx       = bus.req_addr[LD+LB-1:LB];
  assign lane       = bus.req_addr[LB-1:0];
  assign size_bytes = 4'(1) << bus.req_size;
  assign err        = (size_bytes > 4'(BYTES)) || (|(lane & LB'(size_bytes - 4'd1)))
                      || (|(bus.req_addr >> (LD + LB)));
  assign accept     = (st == IDLE) && bus.req_valid;
  assign wr_en      = accept && bus.req_write && !err;
  assign rd_en      = accept && !bus.req_write && !err;
  assign wdata_sh   = bus.req_wdata << {lane, 3'b000};
  always_comb begin
    be = '0;
    for (int i = 0; i < BYTES; i++)
      be[i] = (i >= int'(lane)) && (i < int'(lane) + int'(size_bytes));
  end
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int i = 0; i < BYTES; i++)
        if (be[i]) mem[widx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
    if (rd_en) rd_word <= mem[widx];
  end
  // Shifting 1 by the full width wraps to 0, so the mask becomes all ones for full-width loads.
  always_comb begin
    shifted = rd_word >> {lane_q, 3'b000};
    lo_mask = (DATA_WIDTH'(1) << (7'd8 << sz_q)) - DATA_WIDTH'(1);
    ext     = (shifted & lo_mask)
              | ((!uns_q && |(shifted & (lo_mask ^ (lo_mask >> 1)))) ? ~lo_mask : '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt            = st;
    bus.req_ready  = st == IDLE;
    bus.resp_valid = st == RESP;
    if (accept) nxt = (err || bus.req_write) ? RESP : READ;
    else if (st == READ) nxt = RESP;
    else if (st == RESP && bus.resp_ready) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.resp_rdata <= '0;
      bus.resp_error <= 1'b0;
      sz_q           <= '0;
      uns_q          <= 1'b0;
      lane_q         <= '0;
    end else if (accept) begin
      bus.resp_rdata <= '0;
      bus.resp_error <= err;
      sz_q           <= bus.req_size;
      uns_q          <= bus.req_unsigned;
      lane_q         <= lane;
    end else if (st == READ) begin
      bus.resp_rdata <= ext;
    end else if (st == RESP && bus.resp_ready) begin
      bus.resp_rdata <= '0;
      bus.resp_error <= 1'b0;
    end
`ifdef DMEM_ERR_COUNT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (accept && err && cnt != '1) cnt <= cnt + 16'd1;
  assign err_count = cnt;
`else
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed and random checks of data_memory_ctrl against a byte-array reference model.
module tb_data_memory_ctrl;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [15:0] err_count;
  int          total = 0;
  int          bad = 0;
  int          errs_m = 0;
  logic [7:0]  mem_m [1024];
  data_memory_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus();
  data_memory_ctrl #(.DATA_WIDTH(32), .DEPTH(256), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .err_count(err_count)
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: memory is a flat byte array, loads assemble little-endian bytes and extend arithmetically.
  task automatic model(input bit w, input logic [1:0] sz, input bit u, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output bit er);
    int nb;
    longint v;
    nb = 1 << sz;
    er = (nb > 4) || (a % nb != 0) || (a >= 1024);
    rd = 0;
    if (er) begin
      if (errs_m < 65535) errs_m++;
    end else if (w) begin
      for (int k = 0; k < nb; k++) mem_m[a + k] = d[8*k +: 8];
    end else begin
      v = 0;
      for (int k = 0; k < nb; k++) v = v | (longint'(mem_m[a + k]) << (8 * k));
      if (!u && v[8*nb-1]) v = v - (longint'(1) << (8 * nb));
      rd = v[31:0];
    end
  endtask

  task automatic req(input bit w, input logic [1:0] sz, input bit u, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd, output bit er, output int lat);
    bus.req_valid = 1; bus.req_write = w; bus.req_size = sz;
    bus.req_unsigned = u; bus.req_addr = a; bus.req_wdata = d;
    @(posedge clk); #1;
    bus.req_valid = 0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    rd = bus.resp_rdata;
    er = bus.resp_error;
    @(posedge clk); #1;
  endtask

  task automatic txn(input string tag, input bit w, input logic [1:0] sz, input bit u,
                     input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd);
    logic [31:0] erd;
    bit er, eer;
    int lat;
    model(w, sz, u, a, d, erd, eer);
    req(w, sz, u, a, d, rd, er, lat);
    check({tag, "_rdata"}, rd, erd);
    check({tag, "_err"}, 32'(er), 32'(eer));
    check({tag, "_lat"}, lat, (eer || w) ? 1 : 2);
  endtask

  initial begin
    logic [31:0] rd, held;
    bit          er;
    int          lat, exp_cnt;
    bit          w, u;
    logic [1:0]  sz;
    logic [31:0] a;
    bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0; bus.req_unsigned = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.resp_ready = 1;
    #2;
    check("rst_req_ready", 32'(bus.req_ready), 1);
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_rdata", bus.resp_rdata, 0);
    check("rst_error", 32'(bus.resp_error), 0);
    check("rst_err_count", 32'(err_count), 0);
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] erd;
      bit eer;
      model(1, 2, 0, i * 4, $urandom, erd, eer);
      req(1, 2, 0, i * 4, {mem_m[i*4+3], mem_m[i*4+2], mem_m[i*4+1], mem_m[i*4]}, rd, er, lat);
    end
    txn("st_w", 1, 2, 0, 32'h10, 32'hDEADBEEF, rd);
    check("st_w_zero", rd, 32'h0);
    txn("ld_w", 0, 2, 0, 32'h10, 0, rd);
    check("ld_w_val", rd, 32'hDEADBEEF);
    txn("st_b", 1, 0, 0, 32'h12, 32'h80, rd);
    txn("ld_w2", 0, 2, 0, 32'h10, 0, rd);
    check("ld_w2_val", rd, 32'hDE80BEEF);
    txn("ld_bs", 0, 0, 0, 32'h12, 0, rd);
    check("ld_bs_val", rd, 32'hFFFFFF80);
    txn("ld_bu", 0, 0, 1, 32'h12, 0, rd);
    check("ld_bu_val", rd, 32'h00000080);
    txn("ld_hs", 0, 1, 0, 32'h12, 0, rd);
    check("ld_hs_val", rd, 32'hFFFFDE80);
    txn("e_mis", 0, 1, 0, 32'h13, 0, rd);
    txn("e_oor", 1, 2, 0, 32'h400, 32'h12345678, rd);
    txn("e_sz3", 0, 3, 0, 32'h10, 0, rd);
    txn("ld_unch", 0, 2, 0, 32'h10, 0, rd);
    check("ld_unch_val", rd, 32'hDE80BEEF);
`ifdef DMEM_ERR_COUNT_EN
    exp_cnt = 3;
`else
    exp_cnt = 0;
`endif
    check("err_count3", 32'(err_count), exp_cnt);
    bus.resp_ready = 0;
    bus.req_valid = 1; bus.req_write = 0; bus.req_size = 2; bus.req_unsigned = 0; bus.req_addr = 32'h10;
    @(posedge clk); #1;
    bus.req_valid = 0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    check("bp_lat", lat, 2);
    held = bus.resp_rdata;
    check("bp_rdata", held, 32'hDE80BEEF);
    bus.req_valid = 1; bus.req_write = 1; bus.req_addr = 32'h10; bus.req_wdata = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(bus.resp_valid), 1);
      check("bp_hold", bus.resp_rdata, 32'hDE80BEEF);
      check("bp_error", 32'(bus.resp_error), 0);
      check("bp_ready", 32'(bus.req_ready), 0);
    end
    bus.req_valid = 0;
    bus.resp_ready = 1;
    @(posedge clk); #1;
    check("bp_idle_ready", 32'(bus.req_ready), 1);
    check("bp_idle_valid", 32'(bus.resp_valid), 0);
    check("bp_idle_rdata", bus.resp_rdata, 0);
    txn("bp_after", 0, 2, 0, 32'h10, 0, rd);
    check("bp_after_val", rd, 32'hDE80BEEF);
    bus.req_valid = 1; bus.req_write = 0; bus.req_size = 2; bus.req_addr = 32'h10;
    @(posedge clk); #1;
    bus.req_valid = 0;
    #2 rst_n = 0;
    #1;
    check("mr_req_ready", 32'(bus.req_ready), 1);
    check("mr_resp_valid", 32'(bus.resp_valid), 0);
    check("mr_rdata", bus.resp_rdata, 0);
    check("mr_err_count", 32'(err_count), 0);
    errs_m = 0;
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("mr_no_resp", 32'(bus.resp_valid), 0);
    end
    txn("mr_ld", 0, 2, 0, 32'h10, 0, rd);
    check("mr_ld_val", rd, 32'hDE80BEEF);
    for (int i = 0; i < 300; i++) begin
      w  = 1'($urandom);
      u  = 1'($urandom);
      sz = 2'($urandom);
      a  = ($urandom_range(0, 9) == 0) ? $urandom_range(1024, 2047) : $urandom_range(0, 1023);
      txn("rnd", w, sz, u, a, $urandom, rd);
    end
`ifdef DMEM_ERR_COUNT_EN
    exp_cnt = errs_m;
`else
    exp_cnt = 0;
`endif
    check("err_count_end", 32'(err_count), exp_cnt);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
